// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module : clk_div_pkg
// Brief  : Shared constants and config validation for the multi-channel divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

  localparam int CNT_W_DEF = 20;
  localparam int MIN_DIV   = 2;
  localparam int MIN_HIGH  = 1;

  // A period must leave at least one low cycle, hence high strictly below div.
  function automatic logic cfg_ok(input logic [31:0] div, input logic [31:0] high);
    return (div >= 32'(MIN_DIV)) && (high >= 32'(MIN_HIGH)) && (high < div);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ============================================================================
// Module : clk_div_chan
// Brief  : One divider channel with double-buffered period/high time.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_DIV  = 500000,
  parameter int DEF_HIGH = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] high_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] shadow_div_q, shadow_high_q;
  logic             pend_q, pend_d;
  logic             run_q;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap, restart, apply;

  always_comb begin
    wrap    = (cnt_q == div_q - CNT_W'(1));
    restart = ~run_q | sync_i;
    // Shadow values only become active on a period boundary or while idle.
    apply   = pend_q & (~en_i | restart | wrap);
    div_d   = apply ? shadow_div_q  : div_q;
    high_d  = apply ? shadow_high_q : high_q;
    pend_d  = (pend_q & ~apply) | load_i;
    if (!en_i) begin
      cnt_d = '0;
    end else if (restart || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    clk_d  = en_i & (cnt_d < high_d);
    tick_d = en_i & (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      div_q         <= CNT_W'(DEF_DIV);
      high_q        <= CNT_W'(DEF_HIGH);
      shadow_div_q  <= '0;
      shadow_high_q <= '0;
      pend_q        <= 1'b0;
      run_q         <= 1'b0;
      clk_q         <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      high_q <= high_d;
      pend_q <= pend_d;
      run_q  <= en_i;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      if (load_i) begin
        shadow_div_q  <= div_i;
        shadow_high_q <= high_i;
      end
    end
  end

  assign pend_o = pend_q;
  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
// Module : clk_div_multi
// Brief  : Multi-channel programmable clock/tick divider with config handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = CNT_W_DEF,
  parameter  int DEF_DIV  = 500000,
  parameter  int DEF_HIGH = 250000,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam int CH_SPAN = 1 << CH_W;

  logic [NUM_CH-1:0]  pend;
  logic [CH_SPAN-1:0] pend_all;
  logic [CH_SPAN-1:0] ch_exists;
  logic               xfer;
  logic               cfg_good;
  logic               cfg_err_q;

  // Channel numbers beyond NUM_CH are always ready and always rejected.
  for (genvar i = 0; i < CH_SPAN; i++) begin : g_span
    if (i < NUM_CH) begin : g_real
      assign pend_all[i]  = pend[i];
      assign ch_exists[i] = 1'b1;
    end else begin : g_none
      assign pend_all[i]  = 1'b0;
      assign ch_exists[i] = 1'b0;
    end
  end

  assign cfg_ready = ~pend_all[cfg_ch];
  assign xfer      = cfg_valid & cfg_ready;
  assign cfg_good  = ch_exists[cfg_ch] & cfg_ok(32'(cfg_div), 32'(cfg_high));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= xfer & ~cfg_good;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en[i]),
      .sync_i (sync_start),
      .load_i (xfer & cfg_good & (cfg_ch == CH_W'(i))),
      .div_i  (cfg_div),
      .high_i (cfg_high),
      .pend_o (pend[i]),
      .clk_o  (clk_out[i]),
      .tick_o (tick[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
// Module : tb_clk_div_multi
// Brief  : Scoreboard bench for clk_div_multi with a cycle-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_multi;

  localparam int NCH = 4;
  localparam int CW  = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           sync_start;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [CW-1:0]  cfg_high;
  logic           cfg_err;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  clk_div_multi #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .DEF_DIV  (10),
    .DEF_HIGH (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sync_start (sync_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tick;
    logic           err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_cnt[NCH], m_div[NCH], m_high[NCH], m_pdiv[NCH], m_phigh[NCH];
  bit   m_pend[NCH], m_run[NCH];
  int   hi_cnt[NCH], tk_cnt[NCH];
  int   err_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c]  = 0;
      m_div[c]  = 10;
      m_high[c] = 5;
      m_pend[c] = 1'b0;
      m_run[c]  = 1'b0;
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NCH; c++) begin
      hi_cnt[c] = 0;
      tk_cnt[c] = 0;
    end
    err_cnt = 0;
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    exp_t g;
    bit   rdy, xfer, good, wrap;
    e = '0;
    #1;
    rdy = !m_pend[cfg_ch];
    check_val("cfg_ready", cfg_ready, rdy);
    xfer = cfg_valid && rdy;
    good = (cfg_div >= 2) && (cfg_high >= 1) && (cfg_high < cfg_div);
    for (int c = 0; c < NCH; c++) begin
      wrap = (m_cnt[c] == m_div[c] - 1);
      if (m_pend[c] && (!en[c] || !m_run[c] || sync_start || wrap)) begin
        m_div[c]  = m_pdiv[c];
        m_high[c] = m_phigh[c];
        m_pend[c] = 1'b0;
      end
      if (!en[c]) begin
        m_cnt[c] = 0;
        m_run[c] = 1'b0;
      end else begin
        m_cnt[c]  = (!m_run[c] || sync_start || wrap) ? 0 : m_cnt[c] + 1;
        m_run[c]  = 1'b1;
        e.clk[c]  = (m_cnt[c] < m_high[c]);
        e.tick[c] = (m_cnt[c] == 0);
      end
    end
    e.err = xfer && !good;
    if (xfer && good) begin
      m_pdiv[cfg_ch]  = int'(cfg_div);
      m_phigh[cfg_ch] = int'(cfg_high);
      m_pend[cfg_ch]  = 1'b1;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check_val("clk_out", clk_out, g.clk);
    check_val("tick", tick, g.tick);
    check_val("cfg_err", cfg_err, g.err);
    for (int c = 0; c < NCH; c++) begin
      hi_cnt[c] += int'(clk_out[c]);
      tk_cnt[c] += int'(tick[c]);
    end
    err_cnt += int'(cfg_err);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_cnt(input int c, input int v);
    int k;
    k = 0;
    while (m_cnt[c] != v && k < 50) begin
      step();
      k++;
    end
    check_val("wait_cnt_bound", (k < 50), 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = '0; sync_start = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_clk_out", clk_out, 0);
    check_val("rst_tick", tick, 0);
    check_val("rst_cfg_err", cfg_err, 0);
    check_val("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b0;

    // 1: ch0 alone at reset defaults
    en = 4'b0001;
    clear_counts();
    run(20);
    check_val("s1_ch0_high", hi_cnt[0], 10);
    check_val("s1_ch0_ticks", tk_cnt[0], 2);
    check_val("s1_others_idle", hi_cnt[1] + hi_cnt[2] + hi_cnt[3] + tk_cnt[1] + tk_cnt[2] + tk_cnt[3], 0);

    // 2: reconfigure ch1 mid-period
    en = 4'b0011;
    wait_cnt(1, 3);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 20'd7; cfg_high = 20'd2;
    step();
    cfg_valid = 1'b0;
    #1;
    check_val("s2_ch1_pend_ready", cfg_ready, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[1] && n < 20);
    check_val("s2_old_period_rest", n, 6);
    check_val("s2_ready_after_wrap", cfg_ready, 1);
    clear_counts();
    run(14);
    check_val("s2_ch1_high", hi_cnt[1], 4);
    check_val("s2_ch1_ticks", tk_cnt[1], 2);

    // 3: invalid config rejected
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 20'd1; cfg_high = 20'd0;
    clear_counts();
    step();
    cfg_valid = 1'b0;
    run(3);
    check_val("s3_err_pulses", err_cnt, 1);
    clear_counts();
    run(20);
    check_val("s3_ch0_high", hi_cnt[0], 10);
    check_val("s3_ch0_ticks", tk_cnt[0], 2);

    // 4: back-to-back configs to ch2
    en = 4'b0111;
    run(2);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 20'd6; cfg_high = 20'd3;
    step();
    cfg_div = 20'd8; cfg_high = 20'd4;
    n = 0;
    while (!cfg_ready && n < 30) begin
      step();
      n++;
    end
    check_val("s4_blocked_cycles", n, 8);
    step();
    cfg_valid = 1'b0;
    #1;
    check_val("s4_second_accepted", cfg_ready, 0);

    // 5: sync_start aligns all channels
    en = 4'b1111;
    run(3);
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    check_val("s5_sync_ticks", tick, 4'hF);
    check_val("s5_sync_clk", clk_out, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      step();
      check_val("s5_ch0_phase", clk_out[0], ((k % 10) < 5));
      check_val("s5_ch3_phase", clk_out[3], ((k % 10) < 5));
    end

    // 6: reset mid-period with a pending config
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 20'd4; cfg_high = 20'd1;
    step();
    cfg_valid = 1'b0;
    wait_cnt(0, 6);
    #1;
    check_val("s6_pend_before_rst", cfg_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check_val("s6_rst_clk_out", clk_out, 0);
    check_val("s6_rst_tick", tick, 0);
    check_val("s6_rst_ready", cfg_ready, 1);
    #2;
    rst = 1'b0;
    model_reset();
    clear_counts();
    run(20);
    check_val("s6_ch0_high", hi_cnt[0], 10);
    check_val("s6_ch0_ticks", tk_cnt[0], 2);
    check_val("s6_ch0_ready", cfg_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
